// File: rtl/dram_cmd_responder_if.sv
// Command/response bus between the request scheduler (master) and the DRAM responder (slave).
// Signal names carry the responder's view (_in driven by the scheduler, _out driven by the responder).
interface dram_cmd_responder_if #(
    parameter int BANK_GROUPS     = 8,
    parameter int BANKS_PER_GROUP = 8,
    parameter int ROW_BITS        = 8,
    parameter int COL_BITS        = 4,
    parameter int DATA_W          = 512
);
    localparam int BANKS = BANK_GROUPS * BANKS_PER_GROUP;
    localparam int BG_W  = (BANK_GROUPS > 1) ? $clog2(BANK_GROUPS) : 1;
    localparam int BK_W  = (BANKS_PER_GROUP > 1) ? $clog2(BANKS_PER_GROUP) : 1;

    logic                cmd_valid_in;
    logic [2:0]          cmd_in;
    logic [BG_W-1:0]     bank_group_in;
    logic [BK_W-1:0]     bank_in;
    logic [ROW_BITS-1:0] row_in;
    logic [COL_BITS-1:0] col_in;
    logic [DATA_W-1:0]   val_in;

    logic                cmd_ready_out;
    logic                rd_valid_out;
    logic [DATA_W-1:0]   rd_data_out;
    logic [BG_W-1:0]     rd_bank_group_out;
    logic [BK_W-1:0]     rd_bank_out;
    logic [COL_BITS-1:0] rd_col_out;
    logic                err_valid_out;
    logic [2:0]          err_code_out;
    logic [BANKS-1:0]    bank_active_out;

    modport master (
        output cmd_valid_in, cmd_in, bank_group_in, bank_in, row_in, col_in, val_in,
        input  cmd_ready_out, rd_valid_out, rd_data_out, rd_bank_group_out, rd_bank_out,
               rd_col_out, err_valid_out, err_code_out, bank_active_out
    );

    modport slave (
        input  cmd_valid_in, cmd_in, bank_group_in, bank_in, row_in, col_in, val_in,
        output cmd_ready_out, rd_valid_out, rd_data_out, rd_bank_group_out, rd_bank_out,
               rd_col_out, err_valid_out, err_code_out, bank_active_out
    );
endinterface

// File: rtl/dram_cmd_responder.sv
// DRAM device model: per-bank ACT/PRE timing, REF blocking, word storage, CAS-delayed read return, error pulses.
// Optional feature macro DRAM_RESP_ROW_TAG_EN: store the WR row with each word and flag RD row-tag misses (code 7).
module dram_cmd_responder #(
    parameter int BANK_GROUPS        = 8,
    parameter int BANKS_PER_GROUP    = 8,
    parameter int ROW_BITS           = 8,
    parameter int COL_BITS           = 4,
    parameter int DATA_W             = 512,
    parameter int ACTIVATION_LATENCY = 8,
    parameter int PRECHARGE_LATENCY  = 5,
    parameter int CAS_LATENCY        = 4,
    parameter int REFRESH_LATENCY    = 16
) (
    input logic                 clk_in,
    input logic                 rst_n_in,
    dram_cmd_responder_if.slave bus
);
    localparam int BANKS   = BANK_GROUPS * BANKS_PER_GROUP;
    localparam int BG_W    = (BANK_GROUPS > 1) ? $clog2(BANK_GROUPS) : 1;
    localparam int BK_W    = (BANKS_PER_GROUP > 1) ? $clog2(BANKS_PER_GROUP) : 1;
    localparam int BI_W    = (BANKS > 1) ? $clog2(BANKS) : 1;
    localparam int AW      = BI_W + COL_BITS;
    localparam int DEPTH   = BANKS << COL_BITS;
    localparam int CNT_MAX = (ACTIVATION_LATENCY > PRECHARGE_LATENCY) ? ACTIVATION_LATENCY : PRECHARGE_LATENCY;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int REF_W   = $clog2(REFRESH_LATENCY + 1);

    localparam logic [2:0] CMD_NOP = 3'd0;
    localparam logic [2:0] CMD_ACT = 3'd1;
    localparam logic [2:0] CMD_RD  = 3'd2;
    localparam logic [2:0] CMD_WR  = 3'd3;
    localparam logic [2:0] CMD_PRE = 3'd4;
    localparam logic [2:0] CMD_REF = 3'd5;

    typedef enum logic [1:0] {B_IDLE, B_ACTIVATING, B_ACTIVE, B_PRECHARGING} bank_st_e;

    bank_st_e            st_q     [BANKS];
    logic [CNT_W-1:0]    cnt_q    [BANKS];
    logic [ROW_BITS-1:0] orow_q   [BANKS];
    logic [DEPTH-1:0]    wvld_q;
    logic [DATA_W-1:0]   mem_q    [DEPTH];
`ifdef DRAM_RESP_ROW_TAG_EN
    logic [ROW_BITS-1:0] tag_q    [DEPTH];
`endif
    logic                ready_q;
    logic [REF_W-1:0]    ref_cnt_q;
    logic                rd_vld_pipe_q  [CAS_LATENCY];
    logic [DATA_W-1:0]   rd_data_pipe_q [CAS_LATENCY];
    logic [BG_W-1:0]     rd_bg_pipe_q   [CAS_LATENCY];
    logic [BK_W-1:0]     rd_bk_pipe_q   [CAS_LATENCY];
    logic [COL_BITS-1:0] rd_col_pipe_q  [CAS_LATENCY];
    logic                err_valid_q;
    logic [2:0]          err_code_q;

    logic [BI_W-1:0]     bidx_c;
    logic [AW-1:0]       addr_c;
    bank_st_e            cur_st_c;
    logic                acc_c, go_c, rd_go_c, wr_go_c, all_idle_c, hit_c;
    logic [2:0]          code_c;
    logic [DATA_W-1:0]   rd_word_c;
    logic [BANKS-1:0]    active_c;

    assign bidx_c   = BI_W'(int'(bus.bank_group_in) * BANKS_PER_GROUP + int'(bus.bank_in));
    assign addr_c   = {bidx_c, bus.col_in};
    assign cur_st_c = st_q[bidx_c];
    assign acc_c    = bus.cmd_valid_in && ready_q && (bus.cmd_in != CMD_NOP);

`ifdef DRAM_RESP_ROW_TAG_EN
    assign hit_c = wvld_q[addr_c] && (tag_q[addr_c] == bus.row_in);
`else
    assign hit_c = wvld_q[addr_c];
`endif
    assign rd_word_c = hit_c ? mem_q[addr_c] : '0;

    always_comb begin
        all_idle_c = 1'b1;
        active_c   = '0;
        for (int b = 0; b < BANKS; b++) begin
            if (st_q[b] != B_IDLE) all_idle_c = 1'b0;
            active_c[b] = (st_q[b] == B_ACTIVE);
        end
    end

    always_comb begin
        code_c = 3'd0;
        case (bus.cmd_in)
            CMD_ACT: if (cur_st_c != B_IDLE) code_c = 3'd1;
            CMD_RD, CMD_WR: begin
                if (cur_st_c != B_ACTIVE) code_c = 3'd2;
                else if (bus.row_in != orow_q[bidx_c]) code_c = 3'd3;
`ifdef DRAM_RESP_ROW_TAG_EN
                else if ((bus.cmd_in == CMD_RD) && !hit_c) code_c = 3'd7;
`endif
            end
            CMD_PRE: if ((cur_st_c == B_ACTIVATING) || (cur_st_c == B_PRECHARGING)) code_c = 3'd4;
            CMD_REF: if (!all_idle_c) code_c = 3'd5;
            3'd6, 3'd7: code_c = 3'd6;
            default: code_c = 3'd0;
        endcase
    end

    // A row-tag miss is reported but the read still executes (returns zero).
    assign go_c    = acc_c && ((code_c == 3'd0) || (code_c == 3'd7));
    assign rd_go_c = go_c && (bus.cmd_in == CMD_RD);
    assign wr_go_c = go_c && (bus.cmd_in == CMD_WR);

    always_ff @(posedge clk_in) begin
        if (wr_go_c) begin
            mem_q[addr_c] <= bus.val_in;
`ifdef DRAM_RESP_ROW_TAG_EN
            tag_q[addr_c] <= bus.row_in;
`endif
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int b = 0; b < BANKS; b++) begin
                st_q[b]   <= B_IDLE;
                cnt_q[b]  <= '0;
                orow_q[b] <= '0;
            end
            for (int i = 0; i < CAS_LATENCY; i++) begin
                rd_vld_pipe_q[i]  <= 1'b0;
                rd_data_pipe_q[i] <= '0;
                rd_bg_pipe_q[i]   <= '0;
                rd_bk_pipe_q[i]   <= '0;
                rd_col_pipe_q[i]  <= '0;
            end
            wvld_q      <= '0;
            ready_q     <= 1'b0;
            ref_cnt_q   <= '0;
            err_valid_q <= 1'b0;
            err_code_q  <= 3'd0;
        end else begin
            // Transition one cycle early when the count reaches 1 so the bank is usable
            // exactly LATENCY cycles after the command.
            for (int b = 0; b < BANKS; b++) begin
                if (st_q[b] == B_ACTIVATING || st_q[b] == B_PRECHARGING) begin
                    if (cnt_q[b] <= CNT_W'(1))
                        st_q[b] <= (st_q[b] == B_ACTIVATING) ? B_ACTIVE : B_IDLE;
                    else
                        cnt_q[b] <= cnt_q[b] - 1'b1;
                end
            end

            if (go_c) begin
                case (bus.cmd_in)
                    CMD_ACT: begin
                        st_q[bidx_c]   <= (ACTIVATION_LATENCY <= 1) ? B_ACTIVE : B_ACTIVATING;
                        cnt_q[bidx_c]  <= CNT_W'(ACTIVATION_LATENCY - 1);
                        orow_q[bidx_c] <= bus.row_in;
                    end
                    CMD_PRE: if (cur_st_c == B_ACTIVE) begin
                        st_q[bidx_c]  <= (PRECHARGE_LATENCY <= 1) ? B_IDLE : B_PRECHARGING;
                        cnt_q[bidx_c] <= CNT_W'(PRECHARGE_LATENCY - 1);
                    end
                    CMD_WR: wvld_q[addr_c] <= 1'b1;
                    default: ;
                endcase
            end

            if (ref_cnt_q != '0) begin
                ref_cnt_q <= ref_cnt_q - 1'b1;
                ready_q   <= (ref_cnt_q == REF_W'(1));
            end else if (go_c && (bus.cmd_in == CMD_REF)) begin
                ref_cnt_q <= REF_W'(REFRESH_LATENCY);
                ready_q   <= 1'b0;
            end else begin
                ready_q <= 1'b1;
            end

            err_valid_q <= acc_c && (code_c != 3'd0);
            err_code_q  <= acc_c ? code_c : 3'd0;

            rd_vld_pipe_q[0]  <= rd_go_c;
            rd_data_pipe_q[0] <= rd_go_c ? rd_word_c : '0;
            rd_bg_pipe_q[0]   <= rd_go_c ? bus.bank_group_in : '0;
            rd_bk_pipe_q[0]   <= rd_go_c ? bus.bank_in : '0;
            rd_col_pipe_q[0]  <= rd_go_c ? bus.col_in : '0;
            for (int i = 1; i < CAS_LATENCY; i++) begin
                rd_vld_pipe_q[i]  <= rd_vld_pipe_q[i-1];
                rd_data_pipe_q[i] <= rd_data_pipe_q[i-1];
                rd_bg_pipe_q[i]   <= rd_bg_pipe_q[i-1];
                rd_bk_pipe_q[i]   <= rd_bk_pipe_q[i-1];
                rd_col_pipe_q[i]  <= rd_col_pipe_q[i-1];
            end
        end
    end

    assign bus.cmd_ready_out     = ready_q;
    assign bus.rd_valid_out      = rd_vld_pipe_q[CAS_LATENCY-1];
    assign bus.rd_data_out       = rd_data_pipe_q[CAS_LATENCY-1];
    assign bus.rd_bank_group_out = rd_bg_pipe_q[CAS_LATENCY-1];
    assign bus.rd_bank_out       = rd_bk_pipe_q[CAS_LATENCY-1];
    assign bus.rd_col_out        = rd_col_pipe_q[CAS_LATENCY-1];
    assign bus.err_valid_out     = err_valid_q;
    assign bus.err_code_out      = err_code_q;
    assign bus.bank_active_out   = active_c;
endmodule

// File: tb/tb_dram_cmd_responder.sv
// Bench for dram_cmd_responder: directed vector tables, hand sequences for timing corners,
// then random traffic checked against a timestamp-based bank/memory model.
module tb_dram_cmd_responder;
    localparam int DW = 512, NB = 64, ACT_LAT = 8, PRE_LAT = 5, CL = 4, REF_LAT = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    dram_cmd_responder_if #(.BANK_GROUPS(8), .BANKS_PER_GROUP(8), .ROW_BITS(8), .COL_BITS(4), .DATA_W(DW)) bus ();
    dram_cmd_responder #(
        .BANK_GROUPS(8), .BANKS_PER_GROUP(8), .ROW_BITS(8), .COL_BITS(4), .DATA_W(DW),
        .ACTIVATION_LATENCY(ACT_LAT), .PRECHARGE_LATENCY(PRE_LAT), .CAS_LATENCY(CL), .REFRESH_LATENCY(REF_LAT)
    ) dut (.clk_in(clk), .rst_n_in(rst_n), .bus(bus));

    int checks = 0, passed = 0;

    typedef struct {
        int         gap;
        logic [2:0] cmd, bg, bk;
        logic [7:0] row;
        logic [2:0] exp;
    } vec_t;

    typedef struct {
        int          due;
        logic [DW-1:0] d;
        logic [2:0]  bg, bk;
        logic [3:0]  col;
    } rdq_t;

    // Reference model: banks described by the cycle of their last ACT/PRE, not by counters.
    int            cyc;
    int            m_act_t [NB];
    int            m_pre_t [NB];
    bit            m_open  [NB];
    logic [7:0]    m_row   [NB];
    int            ref_t;
    logic [DW-1:0] mmem [int];
    logic [7:0]    mtag [int];
    rdq_t          rq [$];

    function automatic int bstate(int b);  // 0 idle, 1 activating, 2 active, 3 precharging
        if (m_open[b]) return (cyc < m_act_t[b] + ACT_LAT) ? 1 : 2;
        return (cyc < m_pre_t[b] + PRE_LAT) ? 3 : 0;
    endfunction

    function automatic logic [DW-1:0] rand512();
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        bus.cmd_valid_in = 1'b0;
        bus.cmd_in       = 3'd0;
    endtask

    task automatic idle(input int n);
        nop();
        repeat (n) step();
    endtask

    task automatic drv(input logic [2:0] c, input logic [2:0] g, input logic [2:0] k,
                       input logic [7:0] r, input logic [3:0] co, input logic [DW-1:0] v);
        bus.cmd_valid_in  = 1'b1;
        bus.cmd_in        = c;
        bus.bank_group_in = g;
        bus.bank_in       = k;
        bus.row_in        = r;
        bus.col_in        = co;
        bus.val_in        = v;
    endtask

    task automatic apply(input vec_t v, input string nm);
        idle(v.gap);
        drv(v.cmd, v.bg, v.bk, v.row, 4'd0, '0);
        step();
        nop();
        chk(nm, DW'({bus.err_valid_out, bus.err_code_out}), DW'({v.exp != 3'd0, v.exp}));
    endtask

    task automatic chk_rd(input string nm, input logic [DW-1:0] d, input logic [2:0] g,
                          input logic [2:0] k, input logic [3:0] co);
        chk({nm, "_v"}, DW'(bus.rd_valid_out), DW'(1'b1));
        chk({nm, "_d"}, bus.rd_data_out, d);
        chk({nm, "_a"}, DW'({bus.rd_bank_group_out, bus.rd_bank_out, bus.rd_col_out}), DW'({g, k, co}));
    endtask

    task automatic model_cmd(input logic [2:0] c, input logic [2:0] g, input logic [2:0] k,
                             input logic [7:0] r, input logic [3:0] co, input logic [DW-1:0] v,
                             output logic [2:0] code);
        int b, a, s;
        rdq_t e;
        b = int'(g) * 8 + int'(k);
        a = b * 16 + int'(co);
        s = bstate(b);
        code = 3'd0;
        case (c)
            3'd1: if (s != 0) code = 3'd1;
                  else begin m_open[b] = 1'b1; m_act_t[b] = cyc; m_row[b] = r; end
            3'd2, 3'd3: begin
                if (s != 2) code = 3'd2;
                else if (r != m_row[b]) code = 3'd3;
                else if (c == 3'd3) begin mmem[a] = v; mtag[a] = r; end
                else begin
                    e.due = cyc + CL; e.bg = g; e.bk = k; e.col = co;
                    e.d = mmem.exists(a) ? mmem[a] : '0;
`ifdef DRAM_RESP_ROW_TAG_EN
                    if (!mmem.exists(a) || mtag[a] != r) begin e.d = '0; code = 3'd7; end
`endif
                    rq.push_back(e);
                end
            end
            3'd4: if (s == 1 || s == 3) code = 3'd4;
                  else if (s == 2) begin m_open[b] = 1'b0; m_pre_t[b] = cyc; end
            3'd5: begin
                for (int i = 0; i < NB; i++) if (bstate(i) != 0) code = 3'd5;
                if (code == 3'd0) ref_t = cyc;
            end
            default: code = 3'd6;
        endcase
    endtask

    initial begin
        vec_t t1[6];
        vec_t t2[9];
        logic [DW-1:0] vv[4];
        logic [NB-1:0] act_e;
        logic [2:0] pend, c, g, k, code;
        logic [7:0] r;
        logic [3:0] co;
        logic [DW-1:0] v;
        logic vl, rdy;
        rdq_t e;
        int rr;

        t1[0] = '{0, 3'd1, 3'd2, 3'd1, 8'hF0, 3'd0};
        t1[1] = '{6, 3'd2, 3'd2, 3'd1, 8'hF0, 3'd2};
        t1[2] = '{0, 3'd2, 3'd2, 3'd1, 8'h0F, 3'd3};
        t1[3] = '{0, 3'd4, 3'd2, 3'd1, 8'h00, 3'd0};
        t1[4] = '{3, 3'd1, 3'd2, 3'd1, 8'hF0, 3'd1};
        t1[5] = '{0, 3'd1, 3'd2, 3'd1, 8'hF0, 3'd0};
        t2[0] = '{0, 3'd5, 3'd0, 3'd0, 8'h00, 3'd5};
        t2[1] = '{0, 3'd6, 3'd0, 3'd0, 8'h00, 3'd6};
        t2[2] = '{0, 3'd7, 3'd0, 3'd0, 8'h00, 3'd6};
        t2[3] = '{0, 3'd3, 3'd0, 3'd0, 8'h00, 3'd2};
        t2[4] = '{0, 3'd4, 3'd2, 3'd1, 8'h00, 3'd0};
        t2[5] = '{0, 3'd4, 3'd2, 3'd1, 8'h00, 3'd4};
        t2[6] = '{0, 3'd4, 3'd3, 3'd2, 8'h00, 3'd0};
        t2[7] = '{0, 3'd4, 3'd0, 3'd5, 8'h00, 3'd0};
        t2[8] = '{3, 3'd5, 3'd0, 3'd0, 8'h00, 3'd0};

        nop();
        drv(3'd0, 3'd0, 3'd0, 8'd0, 4'd0, '0);
        nop();
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", DW'(bus.cmd_ready_out), '0);
        chk("rst_out", DW'({bus.rd_valid_out, bus.err_valid_out, bus.err_code_out, bus.bank_active_out}), '0);
        #2 rst_n = 1'b1;
        step();
        chk("rel_ready", DW'(bus.cmd_ready_out), DW'(1'b1));

        // ACT -> WR at +8 -> RD at +9 -> data at +13
        drv(3'd1, 3'd3, 3'd2, 8'h55, 4'd0, '0);
        step(); nop();
        chk("t2_act_err", DW'(bus.err_valid_out), '0);
        repeat (6) step();
        chk("t2_act_t7", DW'(bus.bank_active_out[26]), '0);
        step();
        chk("t2_act_t8", DW'(bus.bank_active_out[26]), DW'(1'b1));
        drv(3'd3, 3'd3, 3'd2, 8'h55, 4'hA, DW'(64'hA5A5A5A5A5A5A5A5));
        step();
        drv(3'd2, 3'd3, 3'd2, 8'h55, 4'hA, '0);
        step(); nop();
        chk("t2_noerr", DW'(bus.err_valid_out), '0);
        chk("t2_early", DW'(bus.rd_valid_out), '0);
        repeat (3) step();
        chk_rd("t2_rd", DW'(64'hA5A5A5A5A5A5A5A5), 3'd3, 3'd2, 4'hA);
        step();
        chk("t2_pulse", DW'(bus.rd_valid_out), '0);

        for (int i = 0; i < 6; i++) apply(t1[i], $sformatf("t1_vec%0d", i));
        for (int i = 1; i < 8; i++) begin
            chk($sformatf("t4_act17_%0d", i), DW'(bus.bank_active_out[17]), '0);
            step();
        end
        chk("t4_act17_8", DW'(bus.bank_active_out[17]), DW'(1'b1));

        for (int i = 0; i < 9; i++) apply(t2[i], $sformatf("t2_vec%0d", i));
        for (int i = 1; i <= REF_LAT; i++) begin
            chk($sformatf("ref_busy%0d", i), DW'(bus.cmd_ready_out), '0);
            step();
        end
        chk("ref_done", DW'(bus.cmd_ready_out), DW'(1'b1));

        // Streaming reads: four back-to-back RDs return on four consecutive cycles
        drv(3'd1, 3'd0, 3'd0, 8'h01, 4'd0, '0);
        step();
        idle(7);
        for (int i = 0; i < 4; i++) begin
            vv[i] = rand512();
            drv(3'd3, 3'd0, 3'd0, 8'h01, 4'(i), vv[i]);
            step();
        end
        for (int i = 0; i < 4; i++) begin
            drv(3'd2, 3'd0, 3'd0, 8'h01, 4'(i), '0);
            step();
        end
        nop();
        for (int i = 0; i < 4; i++) begin
            chk_rd($sformatf("t6_rd%0d", i), vv[i], 3'd0, 3'd0, 4'(i));
            step();
        end
        chk("t6_end", DW'(bus.rd_valid_out), '0);

        // Reset with a read in flight
        drv(3'd2, 3'd0, 3'd0, 8'h01, 4'd0, '0);
        step(); nop();
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst", DW'({bus.cmd_ready_out, bus.rd_valid_out, bus.err_valid_out, bus.bank_active_out}), '0);
        chk("mid_rst_d", bus.rd_data_out, '0);
        step(); step();
        #2 rst_n = 1'b1;
        #1;
        chk("mid_rel0", DW'(bus.cmd_ready_out), '0);
        step();
        chk("mid_rel1", DW'(bus.cmd_ready_out), DW'(1'b1));
        for (int i = 0; i < CL + 1; i++) begin
            chk($sformatf("mid_norv%0d", i), DW'(bus.rd_valid_out), '0);
            step();
        end

        // Random traffic on four banks against the model
        cyc = 0; ref_t = -1000; pend = 3'd0;
        for (int b = 0; b < NB; b++) begin m_open[b] = 1'b0; m_act_t[b] = -100; m_pre_t[b] = -100; m_row[b] = '0; end
        for (int n = 0; n < 1500; n++) begin
            rdy = (cyc > ref_t + REF_LAT);
            for (int b = 0; b < NB; b++) act_e[b] = (bstate(b) == 2);
            chk("r_ready", DW'(bus.cmd_ready_out), DW'(rdy));
            chk("r_active", DW'(bus.bank_active_out), DW'(act_e));
            chk("r_err", DW'({bus.err_valid_out, bus.err_code_out}), DW'({pend != 3'd0, pend}));
            if (rq.size() > 0 && rq[0].due == cyc) begin
                e = rq.pop_front();
                chk_rd("r_rd", e.d, e.bg, e.bk, e.col);
            end else chk("r_norv", DW'(bus.rd_valid_out), '0);
            rr = int'($urandom_range(0, 15));
            case (rr)
                2, 3, 4:  c = 3'd1;
                5, 6, 7:  c = 3'd2;
                8, 9, 10: c = 3'd3;
                11, 12:   c = 3'd4;
                13:       c = 3'd5;
                14:       c = 3'(6 + $urandom_range(0, 1));
                default:  c = 3'd0;
            endcase
            vl = ($urandom_range(0, 7) != 0);
            g = 3'($urandom_range(0, 1)); k = 3'($urandom_range(0, 1));
            r = 8'($urandom_range(0, 1)); co = 4'($urandom_range(0, 3));
            v = rand512();
            drv(c, g, k, r, co, v);
            bus.cmd_valid_in = vl;
            pend = 3'd0;
            if (vl && rdy && c != 3'd0) model_cmd(c, g, k, r, co, v, code);
            else code = 3'd0;
            pend = code;
            step();
            cyc++;
        end
        nop();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
